// File: rtl/data_sram_resp_if.sv
// data_sram_resp_if: CPU data-port bus between the pipeline mem stage and the
// data SRAM responder.
//   ram_ce_i/ram_we_i  access request / store select
//   ram_addr_i         byte address
//   ram_wdata_i        right-aligned store data
//   lsop_i             load/store op code
//   ram_rdata_o        aligned word read data
//   stall_req_o        wait-state stall request towards the CPU
//   err_o              misaligned / out-of-range pulse
// master = CPU side, slave = memory side.
interface data_sram_resp_if;
    logic        ram_ce_i;
    logic        ram_we_i;
    logic [31:0] ram_addr_i;
    logic [31:0] ram_wdata_i;
    logic [3:0]  lsop_i;
    logic [31:0] ram_rdata_o;
    logic        stall_req_o;
    logic        err_o;

    modport master (
        output ram_ce_i, ram_we_i, ram_addr_i, ram_wdata_i, lsop_i,
        input  ram_rdata_o, stall_req_o, err_o
    );

    modport slave (
        input  ram_ce_i, ram_we_i, ram_addr_i, ram_wdata_i, lsop_i,
        output ram_rdata_o, stall_req_o, err_o
    );
endinterface

// File: rtl/data_sram_resp.sv
// data_sram_resp: word-organised data RAM answering the CPU data port with
// synchronous-SRAM timing and optional wait states.
//   clk     system clock, rising edge
//   resetn  asynchronous active-low reset (RAM contents are kept)
//   bus     data_sram_resp_if.slave: request in, rdata/stall/err out
// Read data is registered on the completing edge and is valid the cycle
// after; err_o is registered alongside it.
module data_sram_resp #(
    parameter int          DEPTH_LOG2  = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic           clk,
    input  logic           resetn,
    data_sram_resp_if.slave bus
);
    localparam int WORDS = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        stall, exec;

    logic        lat_we;
    logic [31:0] lat_addr, lat_wdata;
    logic [3:0]  lat_lsop;

    logic [31:0] rdata_q;
    logic        err_q;

    logic [3:0][7:0] mem [WORDS];

    // Operands of the access being executed: live inputs in IDLE, the
    // latched copy once the access has been stretched.
    logic        a_we;
    logic [31:0] a_addr, a_wdata;
    logic [3:0]  a_lsop;

    assign a_we    = (state == S_DONE) ? lat_we    : bus.ram_we_i;
    assign a_addr  = (state == S_DONE) ? lat_addr  : bus.ram_addr_i;
    assign a_wdata = (state == S_DONE) ? lat_wdata : bus.ram_wdata_i;
    assign a_lsop  = (state == S_DONE) ? lat_lsop  : bus.lsop_i;

    // Decode. BASE_ADDR is word aligned, so off[1:0] equals addr[1:0].
    logic [31:0]           off;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  oor, is_load, is_store, is_half, is_word;
    logic                  misal, bad, do_wr, do_rd;
    logic [3:0]            be;
    logic [31:0]           wd;

    always_comb begin
        off      = a_addr - BASE_ADDR;
        idx      = off[DEPTH_LOG2+1:2];
        oor      = (off[31:2] >> DEPTH_LOG2) != '0;
        is_load  = a_lsop inside {[4'd1:4'd5]};
        is_store = a_lsop inside {[4'd6:4'd8]};
        is_half  = a_lsop inside {4'd3, 4'd4, 4'd7};
        is_word  = a_lsop inside {4'd5, 4'd8};
        misal    = (is_half & off[0]) | (is_word & (off[1:0] != 2'b00));
        bad      = misal | oor;
        // Mismatched we/op pairs are silently treated as no access.
        do_wr    = a_we & is_store;
        do_rd    = ~a_we & is_load;
        be       = 4'b0000;
        wd       = a_wdata;
        case (a_lsop)
            4'd6: begin be = 4'b0001 << off[1:0]; wd = {4{a_wdata[7:0]}};  end
            4'd7: begin be = 4'b0011 << off[1:0]; wd = {2{a_wdata[15:0]}}; end
            4'd8: be = 4'b1111;
            default: ;
        endcase
    end

    // FSM next state / outputs
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        exec      = 1'b0;
        case (state)
            S_IDLE: if (bus.ram_ce_i) begin
                if (WAIT_CYCLES == 0) begin
                    exec = 1'b1;
                end else begin
                    stall   = 1'b1;
                    cnt_nxt = 4'(WAIT_CYCLES);
                    // The request cycle already counts as one stall cycle,
                    // so a single wait state needs no WAIT cycle at all.
                    state_nxt = (WAIT_CYCLES == 1) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                stall   = 1'b1;
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd2) state_nxt = S_DONE;
            end
            S_DONE: begin
                exec      = 1'b1;
                cnt_nxt   = 4'd0;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_lsop  <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == S_IDLE && bus.ram_ce_i && WAIT_CYCLES != 0) begin
                lat_we    <= bus.ram_we_i;
                lat_addr  <= bus.ram_addr_i;
                lat_wdata <= bus.ram_wdata_i;
                lat_lsop  <= bus.lsop_i;
            end
            if (exec && do_rd) rdata_q <= bad ? 32'h0 : mem[idx];
            err_q <= exec & (do_rd | do_wr) & bad;
        end
    end

    // RAM array has no reset; the resetn gate drops a store that coincides
    // with reset being asserted.
    always_ff @(posedge clk) begin
        if (resetn && exec && do_wr && !bad) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][b] <= wd[8*b +: 8];
        end
    end

    assign bus.ram_rdata_o = rdata_q;
    assign bus.err_o       = err_q;
    assign bus.stall_req_o = stall;
endmodule
